cpu_bus: RTL
============

CPU_BUS -- requirements
Module: cpu_bus

Interface
REQ-001 Parameter RAM_AW, default 11, internal work-RAM address width (2^RAM_AW bytes).
REQ-002 Parameter RST_VEC, default 16'h8000, value returned for reads of FFFC/FFFD.
REQ-003 Parameter NMI_VEC, default 16'h8000, value returned for reads of FFFA/FFFB.
REQ-004 Parameter IRQ_VEC, default 16'h8000, value returned for reads of FFFE/FFFF.
REQ-005 clk4  in  1  system clock; all state changes on its rising edge.
REQ-006 n_reset  in  1  asynchronous, active-low reset.
REQ-007 ph_en  in  1  one-clk4-cycle strobe marking the bus sample point of each CPU cycle.
REQ-008 addr  in  16  CPU address.
REQ-009 rw  in  1  CPU direction: 1 read, 0 write.
REQ-010 data_in  in  8  CPU write data.
REQ-011 data_out  out  8  registered read data to CPU.
REQ-012 rdy  out  1  CPU ready; 0 halts CPU during DMA.
REQ-013 dma_busy  out  1  high while DMA state is not IDLE.
REQ-014 oam_addr  out  8  sprite-memory write index.
REQ-015 oam_data  out  8  sprite-memory write data.
REQ-016 oam_we  out  1  sprite-memory write strobe, one clk4 cycle wide.

Function
REQ-017 Bus actions occur only on clk4 edges where ph_en=1; other edges hold all state except oam_we clear.
REQ-018 Decode: 0000-1FFF -> RAM at addr[RAM_AW-1:0] (mirrored); FFFA-FFFF -> vector bytes, low byte at even address; all else unmapped.
REQ-019 CPU read (ph_en, rw=1, DMA IDLE): data_out <= decoded byte; valid from that edge until next ph_en edge.
REQ-020 Unmapped read: data_out holds previous value (open bus).
REQ-021 CPU write (ph_en, rw=0, DMA IDLE): RAM byte updated if mapped; data_out <= data_in (bus latch); unmapped writes other than 4014 ignored.
REQ-022 Write to 4014 in IDLE: page <= data_in, idx <= 0, state -> HALT, rdy <= 0 on same edge.
REQ-023 HALT: on ph_en with rw=1 -> READ; with rw=0 stay HALT (CPU finishing write cycles).
REQ-024 READ: on ph_en, buf <= decoded byte at {page, idx} (same decode as REQ-018, open bus = last buf); -> WRITE.
REQ-025 WRITE: on ph_en, oam_addr <= idx, oam_data <= buf, oam_we <= 1 for one clk4 cycle, idx <= idx+1; if idx was FF -> IDLE and rdy <= 1, else -> READ.
REQ-026 Transfer = exactly 256 oam_we pulses, oam_addr 00..FF ascending; 512 ph_en after leaving HALT.
REQ-027 During non-IDLE states CPU addr/rw/data_in ignored; RAM not written by CPU; data_out frozen.
REQ-028 idx 8-bit wraps FF->00 only at transfer end; page unchanged during transfer.
REQ-029 dma_busy = (state != IDLE), combinational from state register.

Reset
REQ-030 n_reset low asynchronously forces: state IDLE, rdy=1, dma_busy=0, data_out=00, oam_addr=00, oam_data=00, oam_we=0, idx=0, page=0, buf=00.
REQ-031 RAM contents not cleared by reset; reset mid-DMA aborts with no further oam_we.

Verification
REQ-032 Reset: n_reset low for 2 clk4 -> rdy=1, dma_busy=0, data_out=00, oam_we=0.
REQ-033 Write 5A to 0012, then read 1812 -> data_out=5A after that ph_en edge; read 0812 -> 5A.
REQ-034 Read FFFC then FFFD (defaults) -> data_out=00 then 80; read 6000 next -> data_out stays 80.
REQ-035 RAM 0200-02FF = i^FF; write 02 to 4014, rw=0 one more ph_en then rw=1 -> rdy=0, 256 oam_we with oam_addr=i, oam_data=i^FF, rdy=1 after 512th post-HALT ph_en.
REQ-036 Write 4014 during DMA (rw=0 held) -> ignored; page and idx unchanged.
REQ-037 n_reset low after 100th oam_we -> rdy=1 immediately, no further oam_we; new 4014 write restarts at oam_addr 00.

Source files
------------

// File: rtl/cpu_bus.sv
// CPU bus slice: work-RAM/vector decode, open-bus read latch and 256-byte sprite DMA engine.
// Latency: read data registered on the ph_en edge that samples the CPU cycle; one OAM byte per two ph_en.
// Backpressure: rdy drops on the 4014 write edge and halts the CPU until the last OAM byte is written.
//
// Ports:
//   clk4, n_reset            system clock, asynchronous active-low reset
//   ph_en                    one-cycle strobe marking the CPU bus sample point
//   addr, rw, data_in        CPU address, direction (1 = read), write data
//   data_out                 registered read data / bus latch
//   rdy, dma_busy            CPU ready, DMA engine active
//   oam_addr, oam_data, oam_we   sprite-memory write port (one-cycle strobe)
module cpu_bus #(
    parameter int          RAM_AW  = 11,
    parameter logic [15:0] RST_VEC = 16'h8000,
    parameter logic [15:0] NMI_VEC = 16'h8000,
    parameter logic [15:0] IRQ_VEC = 16'h8000
) (
    input  logic        clk4,
    input  logic        n_reset,
    input  logic        ph_en,
    input  logic [15:0] addr,
    input  logic        rw,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        rdy,
    output logic        dma_busy,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        oam_we
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HALT  = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [7:0]  page;
    logic [7:0]  idx;
    logic [7:0]  dma_buf;
    logic [7:0]  ram [0:(1<<RAM_AW)-1];

    logic [15:0] dma_addr;
    logic [8:0]  cpu_dec;
    logic [8:0]  dma_dec;
    logic        cpu_wr;
    logic        oam_load;

    // Returns {hit, byte}. RAM is mirrored through 0000-1FFF; the vector
    // words sit at the top of the map with the low byte at the even address.
    function automatic logic [8:0] decode(input logic [15:0] a, input logic [7:0] ram_byte);
        logic [8:0] r;
        r = 9'h000;
        if (a < 16'h2000) begin
            r = {1'b1, ram_byte};
        end else begin
            case (a)
                16'hFFFA: r = {1'b1, NMI_VEC[7:0]};
                16'hFFFB: r = {1'b1, NMI_VEC[15:8]};
                16'hFFFC: r = {1'b1, RST_VEC[7:0]};
                16'hFFFD: r = {1'b1, RST_VEC[15:8]};
                16'hFFFE: r = {1'b1, IRQ_VEC[7:0]};
                16'hFFFF: r = {1'b1, IRQ_VEC[15:8]};
                default:  r = 9'h000;
            endcase
        end
        return r;
    endfunction

    assign dma_addr = {page, idx};
    assign cpu_dec  = decode(addr, ram[addr[RAM_AW-1:0]]);
    assign dma_dec  = decode(dma_addr, ram[dma_addr[RAM_AW-1:0]]);
    assign cpu_wr   = ph_en && !rw && (state == ST_IDLE);
    assign oam_load = ph_en && (state == ST_WRITE);
    assign dma_busy = (state != ST_IDLE);

    // State register
    always_ff @(posedge clk4 or negedge n_reset) begin
        if (!n_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. HALT waits for the first CPU read cycle so the CPU
    // can complete any write cycles already in flight.
    always_comb begin
        state_nxt = state;
        if (ph_en) begin
            case (state)
                ST_IDLE:  if (!rw && addr == 16'h4014) state_nxt = ST_HALT;
                ST_HALT:  if (rw) state_nxt = ST_READ;
                ST_READ:  state_nxt = ST_WRITE;
                ST_WRITE: state_nxt = (idx == 8'hFF) ? ST_IDLE : ST_READ;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Work RAM: contents deliberately survive reset.
    always_ff @(posedge clk4) begin
        if (cpu_wr && addr < 16'h2000) begin
            ram[addr[RAM_AW-1:0]] <= data_in;
        end
    end

    // Datapath registers. oam_we defaults low every edge so it is exactly
    // one clk4 wide regardless of the ph_en spacing.
    always_ff @(posedge clk4 or negedge n_reset) begin
        if (!n_reset) begin
            data_out <= 8'h00;
            rdy      <= 1'b1;
            page     <= 8'h00;
            idx      <= 8'h00;
            dma_buf  <= 8'h00;
            oam_addr <= 8'h00;
            oam_data <= 8'h00;
            oam_we   <= 1'b0;
        end else begin
            oam_we <= 1'b0;
            if (ph_en && state == ST_IDLE) begin
                if (rw) begin
                    // Unmapped reads leave the previous value on the bus.
                    if (cpu_dec[8]) data_out <= cpu_dec[7:0];
                end else begin
                    data_out <= data_in;
                    if (addr == 16'h4014) begin
                        page <= data_in;
                        idx  <= 8'h00;
                        rdy  <= 1'b0;
                    end
                end
            end
            if (ph_en && state == ST_READ && dma_dec[8]) begin
                dma_buf <= dma_dec[7:0];
            end
            if (oam_load) begin
                oam_addr <= idx;
                oam_data <= dma_buf;
                oam_we   <= 1'b1;
                idx      <= idx + 8'd1;
                if (idx == 8'hFF) rdy <= 1'b1;
            end
        end
    end

endmodule
